// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its divider datapath.
package muldiv_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  // Encodings 6 and 7 are left unused and behave as no-ops.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mult_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_t;

  function automatic logic is_long_op(input mult_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per enabled cycle.
module div_core
  import muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic            enable,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Results of the current iteration are exported so the controller can
  // commit them on the same edge as the final iteration.
  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
  assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (enable) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer owning the architectural HI/LO registers.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  mult_t       op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  muldiv_state_t     state;
  logic [CNT_W-1:0]  cnt;
  mult_t             op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;

  logic              start;
  logic              div_start;
  logic              div_en;
  logic              last_iter;
  logic [31:0]       dvd_in;
  logic [31:0]       dvs_in;
  logic [31:0]       q_mag;
  logic [31:0]       r_mag;
  logic [31:0]       div_lo;
  logic [31:0]       div_hi;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] prod_full;

  assign start     = (state == S_IDLE) && valid_i && !flush_i && is_long_op(op_i);
  assign div_start = start && ((op_i == OP_DIV) || (op_i == OP_DIVU));
  assign div_en    = (state == S_DIV) && !flush_i;
  assign last_iter = (cnt == CNT_W'(1));

  assign busy_o = start || (state == S_MUL) || (state == S_DIV);
  assign done_o = (state == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // Signed division runs on magnitudes; signs are restored at commit time.
  assign dvd_in = ((op_i == OP_DIV) && a_i[31]) ? -a_i : a_i;
  assign dvs_in = ((op_i == OP_DIV) && b_i[31]) ? -b_i : b_i;

  div_core u_div_core (
    .clk      (clk),
    .resetn   (resetn),
    .load     (div_start),
    .enable   (div_en),
    .dividend (dvd_in),
    .divisor  (dvs_in),
    .quo_next (q_mag),
    .rem_next (r_mag)
  );

  always_comb begin
    div_lo = q_mag;
    div_hi = r_mag;
    if (b_q == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
    end else if (op_q == OP_DIV) begin
      if (a_q[31] ^ b_q[31]) div_lo = -q_mag;
      if (a_q[31])           div_hi = -r_mag;
    end
  end

  // A 33-bit extension lets one signed multiplier serve both MULT and MULTU.
  assign mul_a     = $signed({(op_q == OP_MULT) & a_q[31], a_q});
  assign mul_b     = $signed({(op_q == OP_MULT) & b_q[31], b_q});
  assign prod_full = mul_a * mul_b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
            if (div_start) begin
              state <= S_DIV;
              cnt   <= CNT_W'(DIV_ITERS);
            end else begin
              state <= S_MUL;
              cnt   <= CNT_W'(MULT_CYCLES);
            end
          end else if (valid_i && !flush_i) begin
            if (op_i == OP_MTHI) hi_q <= a_i;
            if (op_i == OP_MTLO) lo_q <= a_i;
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (last_iter) begin
              hi_q  <= prod_full[63:32];
              lo_q  <= prod_full[31:0];
              state <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (last_iter) begin
              hi_q  <= div_hi;
              lo_q  <= div_lo;
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench: directed cases plus random traffic against a behavioural model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MC = 3;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        valid  = 1'b0;
  logic        flush  = 1'b0;
  mult_t       op     = OP_MULT;
  logic [31:0] a      = '0;
  logic [31:0] b      = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  muldiv_ctrl #(.MULT_CYCLES(MC)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid_i (valid),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the architectural definition.
  function automatic logic [63:0] ref_res(input mult_t o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] ux;
    logic [63:0] uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      OP_MULT:  return 64'(sx * sy);
      OP_MULTU: return ux * uy;
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit is_long(input mult_t o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // Model: cycles of work left, a done flag, committed HI/LO, pending result.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (flush) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end else if (valid && !flush) begin
      if (is_long(op)) begin
        m_left <= ((op == OP_MULT) || (op == OP_MULTU)) ? MC : DIV_ITERS;
        m_res  <= ref_res(op, a, b);
      end else if (op == OP_MTHI) begin
        m_hi <= a;
      end else if (op == OP_MTLO) begin
        m_lo <= a;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("busy_model", {31'd0, busy},
            {31'd0, (m_left > 0) || (!m_done && valid && !flush && is_long(op))});
      check("done_model", {31'd0, done}, {31'd0, m_done});
      check("hi_model", hi, m_hi);
      check("lo_model", lo, m_lo);
    end
  end

  task automatic run_op(input string name, input mult_t o, input logic [31:0] x,
                        input logic [31:0] y, input bit hold, input logic [31:0] ehi,
                        input logic [31:0] elo, input int elat);
    int n;
    bit seen;
    @(negedge clk);
    valid = 1'b1;
    op = o;
    a = x;
    b = y;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (!hold) valid = 1'b0;
      #2;
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(n), 32'(elat));
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    $display("[TB] %s a=%h b=%h -> hi=%h lo=%h after %0d cycles", name, x, y, hi, lo, n);
  endtask

  task automatic move_to(input string name, input mult_t o, input logic [31:0] x);
    @(negedge clk);
    valid = 1'b1;
    op = o;
    a = x;
    #2;
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    #2;
    check({name, "_value"}, (o == OP_MTHI) ? hi : lo, x);
    $display("[TB] %s %h -> hi=%h lo=%h", name, x, hi, lo);
  endtask

  task automatic flush_div(input int fc);
    int pulses;
    @(negedge clk);
    valid = 1'b1;
    op = OP_DIV;
    a = 32'd100;
    b = 32'd7;
    for (int k = 1; k <= fc; k++) begin
      @(negedge clk);
      valid = 1'b0;
      if (k == fc) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    #2;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #2;
      if (done) pulses++;
    end
    check("flush_no_done", 32'(pulses), 32'd0);
    check("flush_hi", hi, 32'h1234_5678);
    check("flush_lo", lo, 32'h1234_5678);
    $display("[TB] DIV flushed in cycle %0d -> hi=%h lo=%h done pulses=%0d", fc, hi, lo, pulses);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("MULT", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC + 1);
    run_op("MULTU", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd2, 32'hFFFF_FFFA, MC + 1);
    run_op("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("DIVU", OP_DIVU, 32'd7, 32'd2, 1'b0, 32'd1, 32'd3, 33);
    run_op("DIVU_by0", OP_DIVU, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 33);
    run_op("DIV_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33);

    run_op("MULT_hold", OP_MULT, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, MC + 1);
    run_op("DIVU_b2b", OP_DIVU, 32'd100, 32'd9, 1'b0, 32'd1, 32'd11, 33);

    move_to("MTHI", OP_MTHI, 32'h1234_5678);
    move_to("MTLO", OP_MTLO, 32'h1234_5678);
    flush_div(20);
    flush_div(32);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    valid = 1'b1;
    op = OP_DIVU;
    a = 32'd1000;
    b = 32'd3;
    repeat (10) begin
      @(negedge clk);
      valid = 1'b0;
    end
    #3;
    resetn = 1'b0;
    #1;
    check("areset_hi", hi, 32'd0);
    check("areset_lo", lo, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    $display("[TB] reset mid-DIV -> hi=%h lo=%h busy=%0b", hi, lo, busy);
    @(negedge clk);
    resetn = 1'b1;
    move_to("MTLO_post_reset", OP_MTLO, 32'hCAFE_F00D);

    // Random traffic, checked every cycle by the model compare process.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      op = mult_t'(3'($urandom_range(0, 7)));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      flush = ($urandom_range(0, 39) == 0);
      if (valid && !flush && !busy && is_long(op))
        $display("[TB] random op=%0d a=%h b=%h", op, a, b);
    end
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
